memory_game_core_n: RTL and testbench

//  Parametrised successor game engine for the pattern-memory game: N switch/LED channels,

---
 rtl/memory_game_core_n.sv | 146 ++++++++++++++
 tb/tb_memory_game_core_n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_core_n.sv
// memory_game_core_n: N-channel pattern-memory game engine (LFSR pattern playback and press checking)
module memory_game_core_n #(
   parameter int          NUM_CH       = 4,
   parameter int          GAME_LIMIT   = 7,
   parameter int          ON_CLKS      = 12500000,
   parameter int          OFF_CLKS     = 6250000,
   parameter int          LIVES        = 1,
   parameter int          TIMEOUT_CLKS = 0,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_Start,
   input  logic [NUM_CH-1:0] i_Switch,
   output logic [NUM_CH-1:0] o_LED,
   output logic [3:0]        o_Score,
   output logic [2:0]        o_Lives,
   output logic              o_Win,
   output logic              o_Lose,
   output logic              o_Busy
);
   localparam int W  = $clog2(NUM_CH);
   localparam int MX = ON_CLKS > OFF_CLKS ? ON_CLKS : OFF_CLKS;
   localparam int CW = MX > 1 ? $clog2(MX) : 1;
   localparam int TW = TIMEOUT_CLKS > 1 ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [CW-1:0]     ON_END  = CW'(ON_CLKS - 1);
   localparam logic [CW-1:0]     OFF_END = CW'(OFF_CLKS - 1);
   localparam logic [TW-1:0]     TO_END  = TW'(TIMEOUT_CLKS - 1);
   localparam logic [3:0]        GL      = 4'(GAME_LIMIT);
   localparam logic [3:0]        GL_END  = 4'(GAME_LIMIT - 1);
   localparam logic [2:0]        LV      = 3'(LIVES);
   localparam logic [NUM_CH-1:0] ONE     = NUM_CH'(1);

   typedef enum logic [2:0] {IDLE, FILL, SHOW_ON, SHOW_OFF, WAIT_IN, RELEASE, WIN, LOSE} state_t;

   state_t            state, state_n;
   logic [15:0]       lfsr;
   logic [W-1:0]      ram [16];
   logic [W-1:0]      sym;
   logic [3:0]        k, k_n, idx, idx_n, score_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [TW-1:0]     tcnt, tcnt_n;
   logic [2:0]        lives_n;
   logic [NUM_CH-1:0] prev, rise, led_n;
   logic              timeout, blink_end;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst && state == FILL) ram[k] <= lfsr[W-1:0];
   end

   always_comb begin
      state_n = state;
      k_n = k;
      idx_n = idx;
      cnt_n = cnt + 1'b1;
      tcnt_n = tcnt + 1'b1;
      score_n = o_Score;
      lives_n = o_Lives;
      rise = i_Switch & ~prev;
      timeout = TIMEOUT_CLKS != 0 && tcnt == TO_END;
      blink_end = cnt == (|o_LED ? ON_END : OFF_END);
      unique case (state)
         IDLE: state_n = i_Start ? FILL : IDLE;
         FILL: begin
            k_n = k + 1'b1;
            if (k == GL_END) begin
               state_n = SHOW_ON;
               idx_n = '0;
               score_n = '0;
               lives_n = LV;
            end
         end
         SHOW_ON: state_n = cnt == ON_END ? SHOW_OFF : SHOW_ON;
         SHOW_OFF: if (cnt == OFF_END) begin
            state_n = idx == o_Score ? WAIT_IN : SHOW_ON;
            idx_n = idx == o_Score ? '0 : idx + 1'b1;
         end
         WAIT_IN: begin
            if (|rise && rise == (ONE << ram[idx])) begin
               tcnt_n = '0;
               idx_n = idx + 1'b1;
               if (idx == o_Score) begin
                  state_n = RELEASE;
                  score_n = o_Score + 1'b1;
               end
            end else if (|rise || timeout) begin
               state_n = o_Lives == 3'd1 ? LOSE : RELEASE;
               lives_n = o_Lives - 1'b1;
            end
         end
         RELEASE: if (!(|i_Switch)) begin
            state_n = o_Score == GL ? WIN : SHOW_ON;
            idx_n = '0;
         end
         WIN, LOSE: begin
            state_n = i_Start ? FILL : state;
            if (blink_end) cnt_n = '0;
         end
      endcase
      if (state_n != state) begin
         cnt_n = '0;
         tcnt_n = '0;
         k_n = '0;
      end
      // with a one-entry pattern, RAM[0] is written on the same edge it is first shown
      sym = state == FILL && k == 4'd0 ? lfsr[W-1:0] : ram[idx_n];
      unique case (state_n)
         SHOW_ON:          led_n = ONE << sym;
         WAIT_IN, RELEASE: led_n = i_Switch;
         WIN, LOSE:        led_n = state_n != state ? '1 : blink_end ? ~o_LED : o_LED;
         default:          led_n = '0;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state <= IDLE;
         lfsr <= LFSR_SEED;
         k <= '0;
         idx <= '0;
         cnt <= '0;
         tcnt <= '0;
         prev <= '0;
         o_LED <= '0;
         o_Score <= '0;
         o_Lives <= LV;
         o_Win <= 1'b0;
         o_Lose <= 1'b0;
         o_Busy <= 1'b0;
      end else begin
         state <= state_n;
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         k <= k_n;
         idx <= idx_n;
         cnt <= cnt_n;
         tcnt <= tcnt_n;
         prev <= i_Switch;
         o_LED <= led_n;
         o_Score <= score_n;
         o_Lives <= lives_n;
         o_Win <= state_n == WIN;
         o_Lose <= state_n == LOSE;
         o_Busy <= state_n == FILL || state_n == SHOW_ON || state_n == SHOW_OFF;
      end
   end
endmodule

// File: tb/tb_memory_game_core_n.sv
// tb_memory_game_core_n: randomized player against a queue-based model of the game rules
module tb_memory_game_core_n;
   localparam int NC = 4, GL = 3, ON = 4, OFF = 2, LV = 2, TO = 20;
   localparam int P_IDLE = 0, P_FILL = 1, P_PLAY = 2, P_WAIT = 3, P_REL = 4, P_END = 5;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [3:0] sw = 4'd0;
   logic [3:0] led, score;
   logic [2:0] lives;
   logic       win, lose, busy;

   memory_game_core_n #(
      .NUM_CH(NC), .GAME_LIMIT(GL), .ON_CLKS(ON), .OFF_CLKS(OFF),
      .LIVES(LV), .TIMEOUT_CLKS(TO), .LFSR_SEED(16'hACE1)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Switch(sw),
      .o_LED(led), .o_Score(score), .o_Lives(lives),
      .o_Win(win), .o_Lose(lose), .o_Busy(busy)
   );

   always #5 clk = ~clk;

   int          ph = P_IDLE, fi = 0, pos = 0, idle = 0, bl = 0, m_score = 0, m_lives = LV;
   bit          m_won = 1'b0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [3:0]  m_led = 4'd0, m_prev = 4'd0;
   int          pat [GL];
   logic [3:0]  seq [$];
   int          n_cmp = 0, n_bad = 0, n_win = 0, n_lose = 0, n_to = 0, n_dbl = 0;
   bit          chk_en = 1'b0, sleepy = 1'b0, did_rst = 1'b0;
   int          pph = -1;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      return 4'b0001 << i;
   endfunction

   // playback is a per-cycle list of LED values: ON cycles lit, OFF cycles dark per element
   task automatic start_play();
      seq.delete();
      for (int i = 0; i <= m_score; i++) begin
         repeat (ON) seq.push_back(oh(pat[i]));
         repeat (OFF) seq.push_back(4'd0);
      end
      m_led = seq.pop_front();
      ph = P_PLAY;
   endtask

   task automatic end_game(input bit won);
      ph = P_END;
      m_won = won;
      bl = 0;
      m_led = 4'hF;
      if (won) n_win++; else n_lose++;
   endtask

   task automatic mistake();
      m_lives--;
      if (m_lives == 0) end_game(1'b0); else ph = P_REL;
   endtask

   task automatic model_step();
      logic [3:0] rise;
      if (rst) begin
         ph = P_IDLE; m_led = 4'd0; m_score = 0; m_lives = LV; m_won = 1'b0;
         m_lfsr = 16'hACE1; m_prev = 4'd0; seq.delete();
         return;
      end
      rise = sw & ~m_prev;
      case (ph)
         P_IDLE: if (start) begin ph = P_FILL; fi = 0; m_led = 4'd0; end
         P_END: begin
            if (start) begin ph = P_FILL; fi = 0; m_led = 4'd0; end
            else begin bl++; m_led = (bl % (ON + OFF)) < ON ? 4'hF : 4'h0; end
         end
         P_FILL: begin
            pat[fi] = int'(m_lfsr[1:0]);
            fi++;
            if (fi == GL) begin m_score = 0; m_lives = LV; start_play(); end
         end
         P_PLAY: begin
            if (seq.size() > 0) m_led = seq.pop_front();
            else begin ph = P_WAIT; pos = 0; idle = 0; m_led = sw; end
         end
         P_WAIT: begin
            m_led = sw;
            if (rise != 4'd0) begin
               idle = 0;
               if ($countones(rise) > 1) n_dbl++;
               if (rise == oh(pat[pos])) begin
                  if (pos == m_score) begin m_score++; ph = P_REL; end
                  else pos++;
               end else mistake();
            end else begin
               idle++;
               if (idle == TO) begin n_to++; mistake(); end
            end
         end
         P_REL: begin
            if (sw == 4'd0) begin
               if (m_score == GL) end_game(1'b1); else start_play();
            end else m_led = sw;
         end
         default: ;
      endcase
      m_prev = sw;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("led", int'(led), int'(m_led));
         check("score", int'(score), m_score);
         check("lives", int'(lives), m_lives);
         check("win", int'(win), int'(ph == P_END && m_won));
         check("lose", int'(lose), int'(ph == P_END && !m_won));
         check("busy", int'(busy), int'(ph == P_FILL || ph == P_PLAY));
      end
   end

   task automatic drive(input int c);
      int r, a;
      start = 1'b0;
      rst = 1'b0;
      r = int'($urandom_range(0, 99));
      if (ph == P_WAIT && pph != P_WAIT) sleepy = $urandom_range(0, 4) == 0;
      pph = ph;
      case (ph)
         P_IDLE, P_END: start = r < 8;
         P_FILL, P_PLAY: begin
            start = r < 3;
            if ($urandom_range(0, 19) == 0) sw = 4'($urandom_range(0, 15));
         end
         P_WAIT: begin
            start = r < 2;
            if (sw != 4'd0) begin
               if ($urandom_range(0, 1) == 0) sw = 4'd0;
            end else if (!sleepy && r >= 20) begin
               if (r < 80) sw = oh(pat[pos]);
               else if (r < 92) sw = oh((pat[pos] + 1 + int'($urandom_range(0, 2))) % 4);
               else begin
                  a = int'($urandom_range(0, 3));
                  sw = oh(a) | oh((a + 1 + int'($urandom_range(0, 2))) % 4);
               end
            end
         end
         P_REL: if ($urandom_range(0, 2) != 0) sw = 4'd0;
         default: ;
      endcase
      if ((!did_rst && c > 5000 && ph == P_PLAY && m_led != 4'd0) || $urandom_range(0, 3999) == 0) begin
         rst = 1'b1;
         did_rst = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_led", int'(led), 0);
      check("rst_score", int'(score), 0);
      check("rst_lives", int'(lives), 2);
      check("rst_flags", int'({win, lose, busy}), 0);
      rst = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", int'(busy), 1);
      check("fill_led", int'(led), 0);
      tick();
      tick();
      tick();
      check("first_led", int'(led), 8);
      check("pat0", pat[0], 3);
      check("pat1", pat[1], 3);
      check("pat2", pat[2], 3);
      tick();
      tick();
      tick();
      check("on_hold", int'(led), 8);
      tick();
      check("off_led", int'(led), 0);
      check("off_busy", int'(busy), 1);
      tick();
      tick();
      check("wait_busy", int'(busy), 0);
      for (int c = 0; c < 30000; c++) begin
         drive(c);
         tick();
      end
      chk_en = 1'b0;
      check("cov_win", int'(n_win > 0), 1);
      check("cov_lose", int'(n_lose > 0), 1);
      check("cov_timeout", int'(n_to > 0), 1);
      check("cov_double", int'(n_dbl > 0), 1);
      check("cov_reset", int'(did_rst), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
